// File: rtl/reg_read_port_pkg.sv
// Shared definitions for the register-file read port.
// Contents: register geometry (XLEN, NREG, IDXW), the index of the hard-zero
// register (XZR_IDX), the flat bus width, and reg_slice(), which extracts one
// register from the flat register-array bus.
package reg_read_port_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int IDXW = 5;
  localparam int BUSW = XLEN * NREG;

  localparam logic [IDXW-1:0] XZR_IDX = 5'd31;

  // Register i occupies bus[XLEN*i +: XLEN].
  function automatic logic [XLEN-1:0] reg_slice(input logic [BUSW-1:0] bus,
                                                input logic [IDXW-1:0] idx);
    return bus[idx*XLEN +: XLEN];
  endfunction

endpackage

// File: rtl/reg_operand_mux.sv
// Combinational operand select for one source register.
// Ports:
//   reg_bus      in  flat register-array contents
//   src_idx      in  source register index
//   wb_reg_write in  write-back commits this cycle
//   wb_reg       in  write-back index
//   wb_data      in  write-back value
//   operand      out selected operand value
// Priority: XZR reads zero, then same-cycle write-back bypass, then the array.
module reg_operand_mux
  import reg_read_port_pkg::*;
(
  input  logic [BUSW-1:0] reg_bus,
  input  logic [IDXW-1:0] src_idx,
  input  logic            wb_reg_write,
  input  logic [IDXW-1:0] wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    operand = reg_slice(reg_bus, src_idx);
    if (src_idx == XZR_IDX) begin
      operand = '0;
    end else if (wb_reg_write && (wb_reg == src_idx)) begin
      // The array only holds the new value after this edge, so forward it.
      operand = wb_data;
    end
  end

endmodule

// File: rtl/reg_read_port.sv
// Read side of the 32x64 register array for the decode/issue stage.
// Ports:
//   Clk, Reset_n               clock, async active-low reset
//   RegBus                     flat register-array contents
//   InValid/InReady            issue request handshake
//   ReadReg1/ReadReg2          source indices
//   DestWrite/DestReg          destination claimed by the request
//   OutValid/OutReady          operand handshake toward the consumer
//   ReadData1/ReadData2        registered operand values
//   WbRegWrite/WbReg/WbData    write-back port (bypass + scoreboard clear)
//   WbSelect                   one-hot write select to the array
//   Flush                      synchronous pipeline flush
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised, is held with its data stable until that transfer
// (or a Flush); ready may depend combinationally on the other side's valid.
module reg_read_port
  import reg_read_port_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [BUSW-1:0] RegBus,
  input  logic            InValid,
  output logic            InReady,
  input  logic [IDXW-1:0] ReadReg1,
  input  logic [IDXW-1:0] ReadReg2,
  input  logic            DestWrite,
  input  logic [IDXW-1:0] DestReg,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  input  logic            WbRegWrite,
  input  logic [IDXW-1:0] WbReg,
  input  logic [XLEN-1:0] WbData,
  output logic [NREG-1:0] WbSelect,
  input  logic            Flush
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] read_data1_q, read_data1_d;
  logic [XLEN-1:0] read_data2_q, read_data2_d;

  logic [XLEN-1:0] operand1, operand2;
  logic [NREG-1:0] wb_onehot, set_mask;
  logic            hz1, hz2, hz_dest, hazard, accept;

  reg_operand_mux u_mux1 (
    .reg_bus      (RegBus),
    .src_idx      (ReadReg1),
    .wb_reg_write (WbRegWrite),
    .wb_reg       (WbReg),
    .wb_data      (WbData),
    .operand      (operand1)
  );

  reg_operand_mux u_mux2 (
    .reg_bus      (RegBus),
    .src_idx      (ReadReg2),
    .wb_reg_write (WbRegWrite),
    .wb_reg       (WbReg),
    .wb_data      (WbData),
    .operand      (operand2)
  );

  always_comb begin
    wb_onehot = '0;
    if (WbRegWrite) wb_onehot[WbReg] = 1'b1;
    // XZR is never written, so its select line stays low.
    WbSelect = wb_onehot;
    WbSelect[XZR_IDX] = 1'b0;

    // A register committing this cycle is no longer a hazard: its value is
    // forwarded by the operand mux. XZR is never busy.
    hz1     = busy_q[ReadReg1] && !wb_onehot[ReadReg1] && (ReadReg1 != XZR_IDX);
    hz2     = busy_q[ReadReg2] && !wb_onehot[ReadReg2] && (ReadReg2 != XZR_IDX);
    hz_dest = DestWrite && busy_q[DestReg] && !wb_onehot[DestReg] &&
              (DestReg != XZR_IDX);
    hazard  = hz1 || hz2 || hz_dest;

    InReady = Reset_n && !hazard && (!out_valid_q || OutReady) && !Flush;
    accept  = InValid && InReady;

    set_mask = '0;
    if (accept && DestWrite && (DestReg != XZR_IDX)) set_mask[DestReg] = 1'b1;

    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;

    if (Flush) begin
      // Operand registers keep their contents; only validity is dropped.
      busy_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      // Set applied after clear: the new issue is younger than the write-back.
      busy_d = (busy_q & ~wb_onehot) | set_mask;
      if (accept) begin
        out_valid_d  = 1'b1;
        read_data1_d = operand1;
        read_data2_d = operand2;
      end else if (OutReady) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      read_data1_q <= '0;
      read_data2_q <= '0;
    end else begin
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
    end
  end

  assign OutValid  = out_valid_q;
  assign ReadData1 = read_data1_q;
  assign ReadData2 = read_data2_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// register file, busy set and operand queue.
module tb_reg_read_port;
  import reg_read_port_pkg::*;

  // ---------------- clock / reset ----------------
  logic            Clk = 1'b0;
  logic            Reset_n;
  always #5 Clk = ~Clk;

  // ---------------- DUT signals ----------------
  logic [BUSW-1:0] RegBus;
  logic            InValid, InReady;
  logic [IDXW-1:0] ReadReg1, ReadReg2, DestReg, WbReg;
  logic            DestWrite, OutValid, OutReady, WbRegWrite, Flush;
  logic [XLEN-1:0] ReadData1, ReadData2, WbData;
  logic [NREG-1:0] WbSelect;

  reg_read_port dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .RegBus     (RegBus),
    .InValid    (InValid),
    .InReady    (InReady),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .DestWrite  (DestWrite),
    .DestReg    (DestReg),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .WbRegWrite (WbRegWrite),
    .WbReg      (WbReg),
    .WbData     (WbData),
    .WbSelect   (WbSelect),
    .Flush      (Flush)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0]   regs_m [NREG];     // register array contents
  bit                busy_m [NREG];     // destinations in flight
  logic [2*XLEN-1:0] exp_q [$];         // operand pairs awaiting hand-off
  logic [XLEN-1:0]   last_rd1, last_rd2; // values the output regs should show

  int checks = 0;
  int errors = 0;

  always_comb begin
    RegBus = '0;
    for (int i = 0; i < NREG; i++) RegBus[i*XLEN +: XLEN] = regs_m[i];
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] model_operand(input int s, input bit wbw,
                                                    input int wbr,
                                                    input logic [XLEN-1:0] wbd);
    if (s == 31) return '0;
    if (wbw && wbr == s) return wbd;
    return regs_m[s];
  endfunction

  function automatic bit model_busy(input int s, input bit wbw, input int wbr);
    return (s != 31) && busy_m[s] && !(wbw && wbr == s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) busy_m[i] = 0;
    exp_q.delete();
    last_rd1 = '0;
    last_rd2 = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit iv, input int r1, input int r2, input bit dw,
                      input int dr, input bit ordy, input bit wbw, input int wbr,
                      input logic [XLEN-1:0] wbd, input bit fl);
    bit              hz, exp_ready, acc;
    logic [XLEN-1:0] o1, o2;
    logic [NREG-1:0] exp_sel;
    @(negedge Clk);
    InValid = iv; ReadReg1 = IDXW'(r1); ReadReg2 = IDXW'(r2);
    DestWrite = dw; DestReg = IDXW'(dr); OutReady = ordy;
    WbRegWrite = wbw; WbReg = IDXW'(wbr); WbData = wbd; Flush = fl;
    #1;
    hz = model_busy(r1, wbw, wbr) || model_busy(r2, wbw, wbr) ||
         (dw && model_busy(dr, wbw, wbr));
    exp_ready = !hz && (exp_q.size() == 0 || ordy) && !fl;
    exp_sel = '0;
    if (wbw && wbr != 31) exp_sel = NREG'(1) << wbr;
    check("in_ready", 64'(InReady), 64'(exp_ready));
    check("wb_select", 64'(WbSelect), 64'(exp_sel));
    check("out_valid", 64'(OutValid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("read_data1", ReadData1, exp_q[0][2*XLEN-1:XLEN]);
      check("read_data2", ReadData2, exp_q[0][XLEN-1:0]);
    end else begin
      check("read_data1_hold", ReadData1, last_rd1);
      check("read_data2_hold", ReadData2, last_rd2);
    end
    acc = iv && exp_ready;
    o1 = model_operand(r1, wbw, wbr, wbd);
    o2 = model_operand(r2, wbw, wbr, wbd);
    if (fl) begin
      for (int i = 0; i < NREG; i++) busy_m[i] = 0;
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (wbw) busy_m[wbr] = 0;
      if (acc) begin
        exp_q.push_back({o1, o2});
        last_rd1 = o1;
        last_rd2 = o2;
        if (dw && dr != 31) busy_m[dr] = 1;
      end
    end
    @(posedge Clk);
    // The array takes the write-back on the same edge.
    if (wbw && wbr != 31) regs_m[wbr] = wbd;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 0, 0, ordy, 0, 0, '0, 0);
  endtask

  function automatic int rnd_idx();
    if ($urandom_range(0, 9) == 0) return 31;
    return int'($urandom_range(0, 7));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0;
    InValid = 0; ReadReg1 = '0; ReadReg2 = '0; DestWrite = 0; DestReg = '0;
    OutReady = 1; WbRegWrite = 0; WbReg = '0; WbData = '0; Flush = 0;
    for (int i = 0; i < NREG; i++) regs_m[i] = {$urandom, $urandom};
    regs_m[31] = {$urandom, $urandom}; // array content of XZR must be ignored
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_in_ready", 64'(InReady), 64'(0));
    check("reset_out_valid", 64'(OutValid), 64'(0));
    check("reset_read_data1", ReadData1, '0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Basic read of 3 and XZR.
    regs_m[3] = 64'h1111;
    step(1, 3, 31, 0, 0, 1, 0, 0, '0, 0);
    idle(1);

    // Same-cycle write-back bypass with stale bus.
    regs_m[5] = 64'h5555;
    step(1, 5, 0, 0, 0, 1, 1, 5, 64'hABCD, 0);
    idle(1);

    // RAW stall on 7 until it commits.
    step(1, 1, 2, 1, 7, 1, 0, 0, '0, 0);
    step(1, 7, 3, 0, 0, 1, 0, 0, '0, 0);
    step(1, 7, 3, 0, 0, 1, 0, 0, '0, 0);
    step(1, 7, 3, 0, 0, 1, 1, 7, 64'h7777, 0);
    idle(1);

    // Backpressure: held outputs, no accept, then release.
    step(1, 4, 6, 0, 0, 1, 0, 0, '0, 0);
    repeat (3) step(1, 1, 2, 0, 0, 0, 0, 0, '0, 0);
    step(1, 1, 2, 0, 0, 1, 0, 0, '0, 0);
    idle(1);

    // Flush with busy {2,9} and an output pending.
    step(1, 0, 0, 1, 2, 1, 0, 0, '0, 0);
    step(1, 0, 0, 1, 9, 1, 0, 0, '0, 0);
    idle(0);
    step(1, 2, 9, 0, 0, 0, 1, 4, 64'h4444, 1);
    step(1, 2, 9, 1, 2, 1, 0, 0, '0, 0);
    idle(1);

    // XZR never becomes busy; write-back to XZR selects nothing.
    step(1, 0, 0, 1, 31, 1, 0, 0, '0, 0);
    step(1, 31, 31, 1, 31, 1, 1, 31, 64'hDEAD, 0);
    idle(1);

    // Async reset in the middle of a stall.
    step(1, 0, 0, 1, 7, 1, 0, 0, '0, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
    @(negedge Clk);
    InValid = 0; WbRegWrite = 0; Flush = 0; OutReady = 1;
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(OutValid), 64'(0));
    check("async_rst_read_data1", ReadData1, '0);
    check("async_rst_read_data2", ReadData2, '0);
    check("async_rst_in_ready", 64'(InReady), 64'(0));
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    step(1, 7, 7, 1, 7, 1, 0, 0, '0, 0);
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rnd_idx(), rnd_idx(),
           $urandom_range(0, 1) == 1, rnd_idx(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, rnd_idx(), {$urandom, $urandom},
           $urandom_range(0, 24) == 0);
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
